// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             wen,
  output logic             full,
  output logic             afull,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ren,
  output logic             empty,
  output logic             aempty,
  output logic [DEPTH:0]   count,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned Entries   = 2 ** DEPTH;
  localparam logic [DEPTH:0] MaxCount  = (DEPTH + 1)'(Entries);
  localparam logic [DEPTH:0] AfullThr  = (DEPTH + 1)'(AFULL_THR);
  localparam logic [DEPTH:0] AemptyThr = (DEPTH + 1)'(AEMPTY_THR);

  logic [WIDTH-1:0] mem_q [Entries];
  logic [DEPTH-1:0] wptr_q, wptr_d;
  logic [DEPTH-1:0] rptr_q, rptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Flags come only from the registered count, so they carry no input paths.
  assign full   = (count_q == MaxCount);
  assign empty  = (count_q == '0);
  assign afull  = (count_q >= AfullThr);
  assign aempty = (count_q <= AemptyThr);
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign dat_o  = mem_q[rptr_q];

  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
      if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
      if (wen && full)  ovf_d = 1'b1;
      if (ren && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_ni && !clr && wr_ok) begin
      mem_q[wptr_q] <= dat_i;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int N  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0, clr = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [7:0] dat_i = '0;
  logic       full, afull, empty, aempty, ovf, udf;
  logic [7:0] dat_o;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_udf;

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(4), .AFULL_THR(AF), .AEMPTY_THR(AE)
  ) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .clr   (clr),
    .dat_i (dat_i),
    .wen   (wen),
    .full  (full),
    .afull (afull),
    .dat_o (dat_o),
    .ren   (ren),
    .empty (empty),
    .aempty(aempty),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  // One clock edge: apply inputs, update the model from pre-edge occupancy, settle.
  task automatic cycle(input bit r, input bit c, input bit w, input bit rd, input logic [7:0] d);
    int sz;
    rst_ni = r; clr = c; wen = w; ren = rd; dat_i = d;
    @(posedge clk);
    sz = q.size();
    if (!r || c) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (w && sz == N) m_ovf = 1;
      if (rd && sz == 0) m_udf = 1;
      if (rd && sz > 0) void'(q.pop_front());
      if (w && sz < N) q.push_back(d);
    end
    #1;
    rst_ni = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 1, 0, 8'hAA);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", aempty); end
    checks++; if (full !== 1'b0 || afull !== 1'b0) begin
      errors++; $display("FAIL reset_full: got full=%b afull=%b want 0 0", full, afull);
    end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin
      errors++; $display("FAIL reset_err: got ovf=%b udf=%b want 0 0", ovf, udf);
    end
    cycle(1, 0, 0, 0, 8'h00);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_nowrite: empty got %b want 1", empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < N; i++) begin
      cycle(1, 0, 1, 0, 8'(i));
      checks++; if (count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      end
      checks++; if (afull !== (i + 1 >= AF) || full !== (i + 1 == N)) begin
        errors++; $display("FAIL fill_flags[%0d]: got afull=%b full=%b", i, afull, full);
      end
      checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL fill_head[%0d]: got %0h want 0", i, dat_o); end
    end
    cycle(1, 0, 1, 0, 8'hEE);
    checks++; if (ovf !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL fill_ovf: got ovf=%b count=%0d want 1 16", ovf, count);
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (dat_o !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, dat_o, i); end
      cycle(1, 0, 0, 1, 8'h00);
    end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL drain_empty: got empty=%b count=%0d", empty, count);
    end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL drain_udf_early: got %b want 0", udf); end
    cycle(1, 0, 0, 1, 8'h00);
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL drain_udf: got %b want 1", udf); end
  endtask

  task automatic test_simultaneous();
    cycle(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      checks++; if (dat_o !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL simul_data[%0d]: got %0h want %0h", i, dat_o, 8'h40 + i);
      end
      cycle(1, 0, 1, 1, 8'(8'h45 + i));
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_count[%0d]: got %0d want 5", i, count); end
    end
  endtask

  task automatic test_boundaries();
    cycle(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < N; i++) cycle(1, 0, 1, 0, 8'(8'h80 + i));
    cycle(1, 0, 1, 1, 8'h55);
    checks++; if (count !== 5'd15 || ovf !== 1'b1) begin
      errors++; $display("FAIL bound_full: got count=%0d ovf=%b want 15 1", count, ovf);
    end
    checks++; if (dat_o !== 8'h81) begin errors++; $display("FAIL bound_full_head: got %0h want 81", dat_o); end
    cycle(1, 1, 0, 0, 8'h00);
    cycle(1, 0, 1, 1, 8'h3C);
    checks++; if (count !== 5'd1 || udf !== 1'b1) begin
      errors++; $display("FAIL bound_empty: got count=%0d udf=%b want 1 1", count, udf);
    end
    checks++; if (dat_o !== 8'h3C) begin errors++; $display("FAIL bound_empty_data: got %0h want 3c", dat_o); end
  endtask

  task automatic test_flush();
    cycle(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < N + 1; i++) cycle(1, 0, 1, 0, 8'(i));
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 1, 8'h00);
    checks++; if (count !== 5'd9 || ovf !== 1'b1) begin
      errors++; $display("FAIL flush_pre: got count=%0d ovf=%b want 9 1", count, ovf);
    end
    cycle(1, 1, 1, 0, 8'h77);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL flush: got count=%0d empty=%b ovf=%b want 0 1 0", count, empty, ovf);
    end
    cycle(1, 0, 0, 0, 8'h00);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_nowrite: empty got %b want 1", empty); end
  endtask

  task automatic test_random();
    int wp, sz;
    bit r, c, w, rd;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Rotate write bias so both the full and empty ends get exercised.
      case ((cyc / 400) % 3)
        0: wp = 80;
        1: wp = 50;
        default: wp = 20;
      endcase
      r  = ($urandom_range(0, 999) != 0);
      c  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < 100 - wp);
      cycle(r, c, w, rd, 8'($urandom));
      sz = q.size();
      checks++; if (count !== 5'(sz)) begin
        errors++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, count, sz);
      end
      checks++; if (empty !== (sz == 0) || full !== (sz == N)) begin
        errors++; $display("FAIL rand_ef@%0d: got empty=%b full=%b size=%0d", cyc, empty, full, sz);
      end
      checks++; if (afull !== (sz >= AF) || aempty !== (sz <= AE)) begin
        errors++; $display("FAIL rand_almost@%0d: got afull=%b aempty=%b size=%0d", cyc, afull, aempty, sz);
      end
      checks++; if (ovf !== m_ovf || udf !== m_udf) begin
        errors++; $display("FAIL rand_err@%0d: got ovf=%b udf=%b want %b %b", cyc, ovf, udf, m_ovf, m_udf);
      end
      if (sz > 0) begin
        checks++; if (dat_o !== q[0]) begin
          errors++; $display("FAIL rand_data@%0d: got %0h want %0h", cyc, dat_o, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_boundaries();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
